// File: rtl/rand_error_injector_if.sv
// RNG request/response and error-vector handshake signals for the injector.
interface rand_error_injector_if #(
    parameter int NUM_SITES = 40
);
    logic                 next_u64;
    logic [63:0]          r;
    logic                 valid;
    logic [NUM_SITES-1:0] error_out;
    logic                 error_valid;
    logic                 error_ready;

    modport master (
        output next_u64,
        input  r,
        input  valid,
        output error_out,
        output error_valid,
        input  error_ready
    );

    modport slave (
        input  next_u64,
        output r,
        output valid,
        input  error_out,
        input  error_valid,
        output error_ready
    );
endinterface

// File: rtl/rand_error_injector.sv
// Draws RNG words and forms one Bernoulli error bit per lattice site by
// comparing each PROB_WIDTH slice against a latched threshold.
module rand_error_injector #(
    parameter int NUM_SITES  = 40,
    parameter int PROB_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PROB_WIDTH-1:0] threshold,
    output logic                  busy,
    output logic [31:0]           round_count,
    rand_error_injector_if.master bus
);
    localparam int SLICES = 64 / PROB_WIDTH;
    localparam int WORDS  = (NUM_SITES + SLICES - 1) / SLICES;
    localparam int CW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t                state;
    state_t                state_d;
    logic [CW-1:0]         word_cnt;
    logic [PROB_WIDTH-1:0] thr_q;
    logic [NUM_SITES-1:0]  acc;
    logic [NUM_SITES-1:0]  acc_d;
    logic [NUM_SITES-1:0]  hit;
    logic [NUM_SITES-1:0]  sel;
    logic [NUM_SITES-1:0]  out_q;
    logic                  take;
    logic                  last;

    // Each site owns a fixed (word, slice) pair; slices past NUM_SITES never exist.
    for (genvar i = 0; i < NUM_SITES; i++) begin : g_site
        localparam int W = i / SLICES;
        localparam int K = i % SLICES;
        assign hit[i] = bus.r[K*PROB_WIDTH +: PROB_WIDTH] < thr_q;
        assign sel[i] = word_cnt == CW'(W);
    end

    assign take  = (state == WAIT) && bus.valid;
    assign last  = word_cnt == LAST;
    assign acc_d = (acc & ~sel) | (hit & sel);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT:    if (bus.valid) state_d = last ? OUT : REQ;
            OUT:     if (bus.error_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt    <= '0;
            thr_q       <= '0;
            acc         <= '0;
            out_q       <= '0;
            round_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                thr_q    <= threshold;
                acc      <= '0;
                word_cnt <= '0;
            end
            if (take) begin
                acc      <= acc_d;
                word_cnt <= word_cnt + 1'b1;
                if (last) out_q <= acc_d;
            end
            if (state == OUT && bus.error_ready)
                round_count <= round_count + 32'd1;
        end
    end

    assign bus.next_u64    = state == REQ;
    assign bus.error_valid = state == OUT;
    assign bus.error_out   = out_q;
    assign busy            = state != IDLE;
endmodule

// File: doc/rand_error_injector.md
Name: rand_error_injector

Overview:
- Consumer side of the rand_gen_stage request/response interface.
- Each round, it requests enough 64-bit random words to cover NUM_SITES lattice sites. Each word is split into PROB_WIDTH-bit slices, and each slice is compared against a programmable threshold to form one Bernoulli error bit per site.
- It packs the bits into an error vector and hands it to the decoder's syndrome stage over a valid/ready handshake.

Parameters:
- NUM_SITES, 40, number of error bits per round (>=1).
- PROB_WIDTH, 16, slice width; must be 8, 16 or 32. SLICES = 64/PROB_WIDTH; WORDS = ceil(NUM_SITES/SLICES).

Ports:
- clk  input  1  single clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a round; sampled only in IDLE.
- threshold  input  PROB_WIDTH  error probability = threshold/2^PROB_WIDTH; latched on accepted start.
- next_u64  output  1  one-cycle request pulse to the RNG.
- r  input  64  RNG output word.
- valid  input  1  r is valid this cycle.
- error_out  output  NUM_SITES  packed error bits; bit i = site i.
- error_valid  output  1  error_out is valid.
- error_ready  input  1  downstream accepts error_out.
- busy  output  1  high in any state except IDLE.
- round_count  output  32  number of completed handshakes; wraps 2^32-1 -> 0.

Behaviour:
- States: IDLE, REQ, WAIT, OUT.
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; word counter=0; latched threshold=0.
  - All outputs 0: next_u64, error_out, error_valid, busy, round_count.
- IDLE:
  - start=1: latch threshold, clear error accumulator and word counter, go to REQ.
  - start=0: stay.
  - valid is ignored in IDLE.
- REQ:
  - next_u64=1 for exactly this one cycle.
  - Next state is WAIT unconditionally.
  - Exactly one outstanding request at a time.
- WAIT:
  - next_u64=0. Stay until valid=1, with no timeout.
  - On valid, for each slice k in 0..SLICES-1:
    - site = word_cnt*SLICES + k.
    - If site < NUM_SITES, accumulator[site] = (r[k*PROB_WIDTH +: PROB_WIDTH] < threshold), unsigned strict compare.
    - Slices with site >= NUM_SITES are discarded.
  - Then word_cnt increments.
  - If that word was word WORDS-1, go to OUT; otherwise go to REQ.
  - Minimum cost per word: 2 cycles plus RNG latency.
- OUT:
  - error_valid=1 and error_out=accumulator, both registered and asserted on the cycle OUT is entered.
  - error_out stays stable while error_ready=0.
  - No next_u64 is issued while in OUT.
  - On error_valid & error_ready: round_count increments; the next cycle has error_valid=0 and state=IDLE.
  - error_out holds its last value until the next round completes.
- start is ignored while busy=1.
- A valid seen outside WAIT is ignored.
- Boundary cases:
  - threshold=0: all bits 0.
  - threshold=all-ones: bit is 0 only when the slice is all-ones.
- Reset mid-round (any state): immediate return to IDLE with outputs cleared. A stale valid arriving after reset release lands in IDLE and is ignored.
- round_count is unaffected by start; only reset clears it.

Test Plan:
1. NUM_SITES=8, PROB_WIDTH=16, threshold=16'h8000.
   - Stub RNG answers each next_u64 after 3 cycles with 64'h0001_8000_FFFF_0000, then 64'h7FFF_7FFF_8001_0000.
   - Expect exactly 2 next_u64 pulses, error_out=8'hD9, error_valid held until error_ready, round_count=1.
2. threshold=0, any r -> error_out all zeros.
   - threshold=16'hFFFF with r=64'hFFFF_FFFF_FFFF_FFFF -> all zeros.
   - threshold=16'hFFFF with r=0 -> all ones.
3. NUM_SITES=6, PROB_WIDTH=16, threshold=16'h0002, r=64'h0000_0000_0000_0000 then 64'h0001_0001_0003_0001.
   - Expect WORDS=2 and error_out=6'b01_1111.
   - Slices 2 and 3 of the second word are discarded; error_out upper bits stay unaffected.
4. Backpressure: hold error_ready=0 for 5 cycles in OUT.
   - error_out stays stable, no next_u64 pulses, start pulses are ignored, busy=1.
   - Raising error_ready gives a handshake in 1 cycle, then IDLE.
5. Assert reset low while in WAIT.
   - All outputs go to 0 immediately.
   - After release, a late valid with r=64'h0 produces no state change and no error_valid.
   - A following start runs a full clean round.
6. Run 3 back-to-back rounds, with start asserted the cycle after each handshake.
   - round_count reads 1, 2, 3.
   - Each round issues exactly WORDS requests.
   - A spurious valid in IDLE is ignored.
